// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the sum-to-BCD path.
// Widths default to the 18-bit adder sum (19 bits with carry).
package calc_pkg;
  localparam int SUM_W      = 19;
  localparam int BCD_DIGITS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble cell: add 3 to a BCD nibble when it is 5 or more.
// Ports: i_nib nibble in, o_nib adjusted nibble out.
module bcd_adj3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);
  // Inputs above 9 never occur, so the 4-bit add cannot carry out.
  assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
endmodule

// File: rtl/sum_bcd_converter.sv
// Serial binary-to-BCD converter, one bit per clock, start/done handshake.
// Ports: clk, reset (async high), start, sum_in -> busy, done, bcd.
module sum_bcd_converter
  import calc_pkg::*;
#(
  parameter int IN_W   = SUM_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       sum_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W);
  localparam int TW = BW + IN_W;
  localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_bcd_work;
  logic [IN_W-1:0] r_bin_work;
  logic [BW-1:0]   r_bcd;

  logic [BW-1:0]   w_adj;
  logic [TW-1:0]   w_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .i_nib (r_bcd_work[4*g +: 4]),
      .o_nib (w_adj[4*g +: 4])
    );
  end

  assign w_shift = {w_adj, r_bin_work} << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bcd_work <= '0;
      r_bin_work <= '0;
      r_bcd      <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state    <= SHIFT;
            r_cnt      <= '0;
            r_bcd_work <= '0;
            r_bin_work <= sum_in;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          {r_bcd_work, r_bin_work} <= w_shift;
          if (r_cnt == LAST) begin
            // Last shift: publish the result on this edge only.
            r_state <= DONE;
            r_bcd   <= w_shift[TW-1:IN_W];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign bcd  = r_bcd;
endmodule

// File: tb/tb_sum_bcd_converter.sv
// Bench for sum_bcd_converter: vector table plus corner-case sequences.
// Inputs change at negedge; a cycle model and result queue check each negedge.
module tb_sum_bcd_converter;
  localparam int IN_W = 19;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [18:0] sum_in = '0;
  logic        busy;
  logic        done;
  logic [23:0] bcd;

  int n_cmp = 0;
  int n_bad = 0;

  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_cnt = 0;
  logic [23:0] m_hold = '0;
  logic [23:0] exp_q[$];

  typedef struct {
    logic [18:0] sum;
    logic [23:0] exp;
  } vec_t;
  vec_t tab[8];

  sum_bcd_converter #(.IN_W(19), .DIGITS(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .sum_in (sum_in),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] bin2bcd(input logic [18:0] v);
    int x;
    logic [23:0] r;
    logic [31:0] d;
    x = int'(v);
    r = '0;
    for (int i = 0; i < 6; i++) begin
      d = 32'(x % 10);
      r[4*i +: 4] = d[3:0];
      x = x / 10;
    end
    return r;
  endfunction

  // One negedge: advance the model over the preceding posedge
  // (inputs are unchanged since then), then compare outputs.
  task automatic tick();
    logic [23:0] e;
    @(negedge clk);
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
      m_hold = '0;
      exp_q.delete();
    end else if (m_busy) begin
      if (m_cnt == IN_W - 1) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end else begin
        m_cnt++;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        exp_q.push_back(bin2bcd(sum_in));
      end
    end
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty_on_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_bcd", 32'(bcd), 32'(e));
        m_hold = e;
      end
    end
    chk("bcd_hold", 32'(bcd), 32'(m_hold));
  endtask

  task automatic conv(input logic [18:0] v, input logic [23:0] exp);
    int  bc;
    bit  seen;
    bc = 0;
    seen = 0;
    start = 1'b1;
    sum_in = v;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      start = 1'b0;
      if (i == 0) sum_in = 19'($urandom_range(0, 524287));
      if (busy === 1'b1) bc++;
      if (done === 1'b1) begin
        seen = 1;
        chk("conv_bcd", 32'(bcd), 32'(exp));
      end
    end
    chk("busy_cycles", bc, 19);
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int t, t1, t2, nd;
    logic [23:0] b1, b2;

    tab[0] = '{19'd0,      24'h000000};
    tab[1] = '{19'd524287, 24'h524287};
    tab[2] = '{19'd99999,  24'h099999};
    tab[3] = '{19'd100000, 24'h100000};
    tab[4] = '{19'd1,      24'h000001};
    tab[5] = '{19'd9,      24'h000009};
    tab[6] = '{19'd10,     24'h000010};
    tab[7] = '{19'd500000, 24'h500000};

    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      conv(tab[i].sum, tab[i].exp);
      tick();
    end

    // Back-to-back with start held high.
    start = 1'b1;
    sum_in = 19'd123456;
    tick();
    sum_in = 19'd262143;
    t1 = -1;
    t2 = -1;
    b1 = '0;
    b2 = '0;
    for (t = 0; t < 60 && t2 < 0; t++) begin
      tick();
      if (t1 >= 0 && t == t1 + 1) start = 1'b0;
      if (done === 1'b1) begin
        if (t1 < 0) begin
          t1 = t;
          b1 = bcd;
        end else begin
          t2 = t;
          b2 = bcd;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first", 32'(b1), 32'h123456);
    chk("b2b_second", 32'(b2), 32'h262143);
    chk("b2b_spacing", t2 - t1, 20);
    repeat (3) tick();

    // Start during SHIFT must be ignored.
    start = 1'b1;
    sum_in = 19'd1000;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    sum_in = 19'd5;
    tick();
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) nd++;
    end
    chk("imm_done_count", nd, 1);
    chk("imm_bcd", 32'(bcd), 32'h001000);

    // Reset part-way through a conversion.
    start = 1'b1;
    sum_in = 19'd314159;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_bcd", 32'(bcd), 32'd0);
    tick();
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1) nd++;
    end
    chk("mid_rst_no_done", nd, 0);
    chk("mid_rst_bcd_after", 32'(bcd), 32'd0);
    conv(19'd42, 24'h000042);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
